// File: rtl/ppm_freq_recovery_pkg.sv
// Shared definitions for the PPM frequency-recovery front end:
// FSM state encodings and a constant-evaluable ceiling log2 helper.
package ppm_freq_recovery_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_TRACK  = 2'd2
  } freq_state_e;

  // Smallest r such that 2**r >= value (0 for value <= 1).
  function automatic int ceil_log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ppm_sat_counter.sv
// Saturating up-counter with enable and synchronous clear.
// A clear together with enable restarts the count at 1, so a window or
// interval can begin on the same edge that counts its first event.
module ppm_sat_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1'b1);
  localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};

  // Count register: clear/restart has priority, otherwise count up and stick at max.
  always_ff @(posedge clk) begin
    if (clear) begin
      count <= enable ? CNT_ONE : CNT_ZERO;
    end else if (enable && (count != CNT_MAX)) begin
      count <= count + CNT_ONE;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/ppm_freq_recovery.sv
// Chip-rate frequency-recovery front end for the 16-PPM SPAD receiver.
// Detects pulses against a threshold, measures the spacing between
// consecutive pulses and counts pulses per symbol-length window.
// The whole block idles while freq_ok is high.
module ppm_freq_recovery
  import ppm_freq_recovery_pkg::*;
#(
  parameter  int CHIP_BITS    = 1,
  parameter  int SYMBOL_CHIPS = 16,
  localparam int W            = ceil_log2(SYMBOL_CHIPS) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CHIP_BITS-1:0] din,
  input  logic [CHIP_BITS-1:0] pulse_threshold,
  input  logic                 freq_ok,
  output logic                 pulse_detected,
  output logic [W-1:0]         interpulse_cycles,
  output logic [1:0]           intrasymbol_pulses,
  output logic [1:0]           FREQ_state_SC,
  output logic [1:0]           FREQ_next_state_SC,
  output logic [1:0]           FREQ_intrasymbol_pulse_count_SC,
  output logic [W-1:0]         FREQ_symbol_cycle_count_SC,
  output logic [W-1:0]         FREQ_interpulse_cycle_count_SC,
  output logic [W-1:0]         FREQ_max_symbol_cycle_count_SC,
  output logic [W-1:0]         FREQ_max_interpulse_cycle_count_SC,
  output logic                 FREQ_increment_symbol_cycle_count_SC,
  output logic                 FREQ_increment_interpulse_cycle_count_SC
);

  localparam logic [W-1:0] SYM_MAX = W'(SYMBOL_CHIPS - 1);
  localparam logic [W-1:0] IP_MAX  = {W{1'b1}};
  localparam logic [W-1:0] W_ONE   = W'(1'b1);

  freq_state_e  state_r;
  freq_state_e  next_state_s;
  logic         pulse_s;
  logic         tracking_s;
  logic         wrap_s;
  logic         ip_clear_s;
  logic         ip_en_s;
  logic         win_clear_s;
  logic         win_en_s;
  logic [1:0]   win_final_s;
  logic [W-1:0] sym_cnt_r;
  logic [W-1:0] ip_cnt_s;
  logic [1:0]   win_cnt_s;

  assign pulse_s = (din >= pulse_threshold);

  // Counter control: enables and clears for the interpulse and window counters.
  always_comb begin
    tracking_s  = (state_r == ST_TRACK) && !freq_ok && !reset;
    wrap_s      = tracking_s && (sym_cnt_r == SYM_MAX);
    // Interpulse: free-runs in TRACK, restarts at 0 on every pulse.
    ip_clear_s  = reset || !tracking_s || pulse_s;
    ip_en_s     = tracking_s && !pulse_s;
    // Window: first pulse in SEARCH opens it at 1; a pulse on the wrap edge
    // belongs to the ending window, so the next one starts at 0.
    win_clear_s = reset || !tracking_s || wrap_s;
    win_en_s    = 1'b0;
    if (!reset && !freq_ok && pulse_s) begin
      if (state_r == ST_SEARCH) begin
        win_en_s = 1'b1;
      end else if (state_r == ST_TRACK) begin
        win_en_s = !wrap_s;
      end else begin
        win_en_s = 1'b0;
      end
    end else begin
      win_en_s = 1'b0;
    end
    // Closing count of the window, including a pulse on the wrap edge.
    if (win_cnt_s == 2'd3) begin
      win_final_s = 2'd3;
    end else begin
      win_final_s = win_cnt_s + {1'b0, pulse_s};
    end
  end

  // Next-state logic: freq_ok forces IDLE from any state.
  always_comb begin
    next_state_s = ST_IDLE;
    if (reset || freq_ok) begin
      next_state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:   next_state_s = ST_SEARCH;
        ST_SEARCH: next_state_s = pulse_s ? ST_TRACK : ST_SEARCH;
        ST_TRACK:  next_state_s = ST_TRACK;
        default:   next_state_s = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Pulse flag, symbol cycle counter and the two measured metrics.
  always_ff @(posedge clk) begin
    if (reset) begin
      pulse_detected     <= 1'b0;
      interpulse_cycles  <= {W{1'b0}};
      intrasymbol_pulses <= 2'd0;
      sym_cnt_r          <= {W{1'b0}};
    end else begin
      pulse_detected <= pulse_s;
      if (tracking_s && pulse_s) begin
        interpulse_cycles <= (ip_cnt_s == IP_MAX) ? IP_MAX : (ip_cnt_s + W_ONE);
      end else begin
        interpulse_cycles <= interpulse_cycles;
      end
      if (wrap_s) begin
        intrasymbol_pulses <= win_final_s;
      end else begin
        intrasymbol_pulses <= intrasymbol_pulses;
      end
      if (!tracking_s || wrap_s) begin
        sym_cnt_r <= {W{1'b0}};
      end else begin
        sym_cnt_r <= sym_cnt_r + W_ONE;
      end
    end
  end

  ppm_sat_counter #(.WIDTH(W)) u_interpulse_cnt (
    .clk    (clk),
    .clear  (ip_clear_s),
    .enable (ip_en_s),
    .count  (ip_cnt_s)
  );

  ppm_sat_counter #(.WIDTH(2)) u_window_cnt (
    .clk    (clk),
    .clear  (win_clear_s),
    .enable (win_en_s),
    .count  (win_cnt_s)
  );

  assign FREQ_state_SC                            = state_r;
  assign FREQ_next_state_SC                       = next_state_s;
  assign FREQ_intrasymbol_pulse_count_SC          = win_cnt_s;
  assign FREQ_symbol_cycle_count_SC               = sym_cnt_r;
  assign FREQ_interpulse_cycle_count_SC           = ip_cnt_s;
  assign FREQ_max_symbol_cycle_count_SC           = SYM_MAX;
  assign FREQ_max_interpulse_cycle_count_SC       = IP_MAX;
  assign FREQ_increment_symbol_cycle_count_SC     = tracking_s;
  assign FREQ_increment_interpulse_cycle_count_SC = ip_en_s;

endmodule

// File: tb/tb_ppm_freq_recovery.sv
// Directed testbench for ppm_freq_recovery (CHIP_BITS=4, SYMBOL_CHIPS=16, W=5).
module tb_ppm_freq_recovery;

  localparam int CB = 4;
  localparam int W  = 5;

  logic          clk;
  logic          reset;
  logic [CB-1:0] din;
  logic [CB-1:0] pulse_threshold;
  logic          freq_ok;
  logic          pulse_detected;
  logic [W-1:0]  interpulse_cycles;
  logic [1:0]    intrasymbol_pulses;
  logic [1:0]    st;
  logic [1:0]    nst;
  logic [1:0]    win_cnt;
  logic [W-1:0]  sym_cnt;
  logic [W-1:0]  ip_cnt;
  logic [W-1:0]  max_sym;
  logic [W-1:0]  max_ip;
  logic          inc_sym;
  logic          inc_ip;

  int n_vec;
  int n_miscomp;

  ppm_freq_recovery #(.CHIP_BITS(CB), .SYMBOL_CHIPS(16)) dut (
    .clk                                      (clk),
    .reset                                    (reset),
    .din                                      (din),
    .pulse_threshold                          (pulse_threshold),
    .freq_ok                                  (freq_ok),
    .pulse_detected                           (pulse_detected),
    .interpulse_cycles                        (interpulse_cycles),
    .intrasymbol_pulses                       (intrasymbol_pulses),
    .FREQ_state_SC                            (st),
    .FREQ_next_state_SC                       (nst),
    .FREQ_intrasymbol_pulse_count_SC          (win_cnt),
    .FREQ_symbol_cycle_count_SC               (sym_cnt),
    .FREQ_interpulse_cycle_count_SC           (ip_cnt),
    .FREQ_max_symbol_cycle_count_SC           (max_sym),
    .FREQ_max_interpulse_cycle_count_SC       (max_ip),
    .FREQ_increment_symbol_cycle_count_SC     (inc_sym),
    .FREQ_increment_interpulse_cycle_count_SC (inc_ip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscomp++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one chip value across one rising edge; outputs are sampled 1 time unit later.
  task automatic step(input logic [CB-1:0] d);
    din = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_miscomp = 0;
    reset = 1'b1;
    freq_ok = 1'b0;
    din = 4'd1;
    pulse_threshold = 4'd1;
    #2;

    // 1. Reset with a pulse present and freq_ok low: everything zero, IDLE.
    step(4'd1);
    check_eq("rst_pulse", {31'd0, pulse_detected}, 32'd0);
    check_eq("rst_state", {30'd0, st}, 32'd0);
    check_eq("rst_ipc", {27'd0, interpulse_cycles}, 32'd0);
    check_eq("rst_isp", {30'd0, intrasymbol_pulses}, 32'd0);
    check_eq("rst_symcnt", {27'd0, sym_cnt}, 32'd0);
    check_eq("max_sym", {27'd0, max_sym}, 32'd15);
    check_eq("max_ip", {27'd0, max_ip}, 32'd31);

    // 2. Lock gating: freq_ok high, pulses every 4 chips.
    freq_ok = 1'b1;
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step((i % 4 == 0) ? 4'd1 : 4'd0);
      if (i % 4 == 0) check_eq("gate_pd_hi", {31'd0, pulse_detected}, 32'd1);
      if (i % 4 == 1) check_eq("gate_pd_lo", {31'd0, pulse_detected}, 32'd0);
    end
    check_eq("gate_state", {30'd0, st}, 32'd0);
    check_eq("gate_ipc", {27'd0, interpulse_cycles}, 32'd0);
    check_eq("gate_isp", {30'd0, intrasymbol_pulses}, 32'd0);

    // 3. Periodic pulses every 16 chips.
    freq_ok = 1'b0;
    step(4'd0);
    check_eq("p16_search", {30'd0, st}, 32'd1);
    step(4'd1);
    check_eq("p16_track", {30'd0, st}, 32'd2);
    check_eq("p16_win1", {30'd0, win_cnt}, 32'd1);
    check_eq("p16_ip0", {27'd0, ip_cnt}, 32'd0);
    for (int i = 0; i < 15; i++) step(4'd0);
    check_eq("p16_sym15", {27'd0, sym_cnt}, 32'd15);
    check_eq("p16_ip15", {27'd0, ip_cnt}, 32'd15);
    step(4'd1);
    check_eq("p16_ipc_a", {27'd0, interpulse_cycles}, 32'd16);
    check_eq("p16_symwrap", {27'd0, sym_cnt}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 15; i++) step(4'd0);
      step(4'd1);
      check_eq("p16_ipc", {27'd0, interpulse_cycles}, 32'd16);
      check_eq("p16_isp", {30'd0, intrasymbol_pulses}, 32'd1);
    end

    // 4. Dense pulses every 4 chips: window aligned, 4 pulses saturate at 3.
    for (int g = 0; g < 4; g++) begin
      step(4'd0);
      step(4'd0);
      step(4'd0);
      step(4'd1);
      if (g == 0) check_eq("d4_ipc", {27'd0, interpulse_cycles}, 32'd4);
      if (g == 2) check_eq("d4_win3", {30'd0, win_cnt}, 32'd3);
    end
    check_eq("d4_isp", {30'd0, intrasymbol_pulses}, 32'd3);
    check_eq("d4_ipc_end", {27'd0, interpulse_cycles}, 32'd4);

    // 5. Saturation: two pulses 40 chips apart after a fresh reset.
    reset = 1'b1;
    step(4'd0);
    reset = 1'b0;
    step(4'd0);
    step(4'd1);
    for (int i = 0; i < 39; i++) step(4'd0);
    check_eq("sat_live", {27'd0, ip_cnt}, 32'd31);
    check_eq("sat_hold0", {27'd0, interpulse_cycles}, 32'd0);
    step(4'd1);
    check_eq("sat_ipc", {27'd0, interpulse_cycles}, 32'd31);
    freq_ok = 1'b1;
    step(4'd0);
    check_eq("lock_state", {30'd0, st}, 32'd0);
    check_eq("lock_hold", {27'd0, interpulse_cycles}, 32'd31);
    check_eq("lock_ipclr", {27'd0, ip_cnt}, 32'd0);

    // 6. Threshold 8 with 4-bit chips.
    pulse_threshold = 4'd8;
    step(4'd7);
    check_eq("thr_7", {31'd0, pulse_detected}, 32'd0);
    step(4'd8);
    check_eq("thr_8", {31'd0, pulse_detected}, 32'd1);
    step(4'd15);
    check_eq("thr_15", {31'd0, pulse_detected}, 32'd1);
    step(4'd0);
    check_eq("thr_0", {31'd0, pulse_detected}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscomp);
    $finish;
  end

endmodule
